// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder/subtractor.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE = 4;

    // Code 2'd3 is unreachable; the FSM decodes it as idle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle of the nibble-serial adder; master drives operands, slave is the adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WORDS = 4
);
    import nibble_serial_adder_pkg::*;

    logic                    start;
    logic                    sub;
    logic                    cin;
    logic [NIBBLE*WORDS-1:0] a;
    logic [NIBBLE*WORDS-1:0] b;
    logic                    busy;
    logic                    done;
    logic [NIBBLE*WORDS-1:0] s;
    logic                    cout;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, s, cout
    );

endinterface

// File: rtl/RCA_4bit.sv
// 4-bit ripple-carry adder built from explicit full-adder cells.
module RCA_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] s,
    output logic              cout
);

    logic [NIBBLE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add/subtract done one nibble per clock through a single 4-bit ripple adder.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int unsigned     Width   = NIBBLE * WORDS;
    localparam int unsigned     IdxW    = $clog2(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [Width-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic             cout_q, cout_d, done_q, done_d;

    logic [NIBBLE-1:0] nib_sum;
    logic              nib_cout;
    logic              accept;

    RCA_4bit u_rca (
        .a    (a_q[NIBBLE*idx_q +: NIBBLE]),
        .b    (b_q[NIBBLE*idx_q +: NIBBLE]),
        .cin  (carry_q),
        .s    (nib_sum),
        .cout (nib_cout)
    );

    // start is honoured in every state except RUN
    assign accept = bus.start && (state_q != StRun);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            StRun: begin
                acc_d[NIBBLE*idx_q +: NIBBLE] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == LastIdx) begin
                    s_d     = acc_d;
                    cout_d  = nib_cout;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Subtract is a + ~b + 1, so the carry-in is forced high.
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub ? 1'b1 : bus.cin;
            idx_d   = '0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WORDS=4) with a done-triggered scoreboard monitor.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    localparam int unsigned WORDS = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WORDS(WORDS)) bus ();

    nibble_serial_adder #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] last_s;
    logic        done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            check("done width", {31'd0, done_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                check("done with empty scoreboard", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("result s", {16'd0, bus.s}, {16'd0, e.s});
                check("result cout", {31'd0, bus.cout}, {31'd0, e.cout});
            end
        end
        done_prev = bus.done;
    end

    // mode 0: plain, 1: start pulse with new operands mid-run, 2: reset mid-run
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic cin, input logic [15:0] es, input logic ec, input int mode);
        bit seen = 1'b0;
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.cin   = cin;
        bus.start = 1'b1;
        e.s = es;
        e.cout = ec;
        if (mode != 2) sb_q.push_back(e);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = 16'(~a);
                bus.b     = 16'($urandom);
                bus.sub   = ~sub;
                bus.cin   = ~cin;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                check("latency", k - 1, WORDS);
                check("busy low at done", {31'd0, bus.busy}, 32'd0);
                last_s = es;
                break;
            end
            check("busy during run", {31'd0, bus.busy}, 32'd1);
            check("s holds during run", {16'd0, bus.s}, {16'd0, last_s});
            if (mode == 1 && k == 2) begin
                bus.start = 1'b1;
                bus.a     = 16'hFFFF;
                bus.b     = 16'hFFFF;
            end
            if (mode == 1 && k == 3) bus.start = 1'b0;
            if (mode == 2 && k == 2) begin
                rst_n = 1'b0;
                #1;
                check("reset busy", {31'd0, bus.busy}, 32'd0);
                check("reset done", {31'd0, bus.done}, 32'd0);
                check("reset s", {16'd0, bus.s}, 32'd0);
                check("reset cout", {31'd0, bus.cout}, 32'd0);
                last_s = 16'h0000;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        check("done timeout", {31'd0, seen}, 32'd1);
    endtask

    vec_t vecs[5] = '{
        '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1},
        '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1},
        '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0},
        '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1}
    };

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        last_s    = 16'h0000;
        repeat (2) @(negedge clk);
        check("init busy", {31'd0, bus.busy}, 32'd0);
        check("init done", {31'd0, bus.done}, 32'd0);
        check("init s", {16'd0, bus.s}, 32'd0);
        check("init cout", {31'd0, bus.cout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].es, vecs[i].ec, 0);
            @(negedge clk);
        end

        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1);
        repeat (3) @(negedge clk);

        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 2);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0);
        @(negedge clk);

        // Second start lands in the first op's done cycle.
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0);

        repeat (8) @(negedge clk);
        check("scoreboard drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
